// File: rtl/ram_clr.sv
// ram_clr: WIDTH x 2^ADDR_BITS word RAM with combinational read and a hardware
// clear engine that zeroes one word per clock after reset or on request.
module ram_clr #(
  parameter int WIDTH          = 16,
  parameter int ADDR_BITS      = 9,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 load,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 busy,
  output logic                 done
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] clr_ptr;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 last_word;

  assign last_word = &clr_ptr;
  assign out       = mem[address];

  // The array has no reset; rst_n only gates writes so nothing lands while held.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (load && !clear) begin
        mem[address] <= in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
      busy    <= CLEAR_ON_RESET;
      clr_ptr <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // Leaving at the last word means clr_ptr never wraps mid-sequence.
          if (last_word) begin
            state   <= IDLE;
            clr_ptr <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + ADDR_BITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_clr.sv
// Testbench for ram_clr: default config, a CLEAR_ON_RESET=0 instance and a
// small 8x8 instance, with expected read data queued and popped on compare.
module tb_ram_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, load_a, clear_a, busy_a, done_a;
  logic [15:0] in_a, out_a;
  logic [8:0]  addr_a;

  logic        rst_n_b, load_b, clear_b, busy_b, done_b;
  logic [15:0] in_b, out_b;
  logic [8:0]  addr_b;

  logic        rst_n_c, load_c, clear_c, busy_c, done_c;
  logic [7:0]  in_c, out_c;
  logic [2:0]  addr_c;

  ram_clr #(.WIDTH(16), .ADDR_BITS(9), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in(in_a), .address(addr_a), .load(load_a),
    .clear(clear_a), .out(out_a), .busy(busy_a), .done(done_a));

  ram_clr #(.WIDTH(16), .ADDR_BITS(9), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in(in_b), .address(addr_b), .load(load_b),
    .clear(clear_b), .out(out_b), .busy(busy_b), .done(done_b));

  ram_clr #(.WIDTH(8), .ADDR_BITS(3), .CLEAR_ON_RESET(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .in(in_c), .address(addr_c), .load(load_c),
    .clear(clear_c), .out(out_c), .busy(busy_c), .done(done_c));

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_a [512];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int          cycles;
    logic [15:0] want;
    int          raddr [3] = '{0, 255, 511};
    tick();
    tick();
    vectors++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state busy=%b done=%b want busy=1 done=0", busy_a, done_a);
    end
    rst_n_a = 1'b1;
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 600) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != 512) begin
      miscompares++;
      $display("[TB] FAIL reset_clear_len got=%0d want=512", cycles);
    end
    vectors++;
    if (done_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_done_rise got=%b want=1", done_a);
    end
    for (int i = 0; i < 3; i++) begin
      addr_a = 9'(raddr[i]);
      exp_q.push_back(16'h0000);
      #1;
      want = exp_q.pop_front();
      vectors++;
      if (out_a !== want) begin
        miscompares++;
        $display("[TB] FAIL reset_read addr=%0d got=%h want=%h", raddr[i], out_a, want);
      end
    end
    tick();
    vectors++;
    if (done_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done_pulse got=%b want=0", done_a);
    end
    for (int i = 0; i < 512; i++) model_a[i] = 16'h0000;
  endtask

  task automatic test_random_rw();
    logic [15:0] want;
    for (int i = 0; i < 1000; i++) begin
      addr_a = 9'(i % 512);
      in_a   = 16'($urandom);
      load_a = 1'b1;
      exp_q.push_back(model_a[addr_a]);
      #1;
      want = exp_q.pop_front();
      vectors++;
      if (out_a !== want) begin
        miscompares++;
        $display("[TB] FAIL rw_before_edge addr=%0d got=%h want=%h", addr_a, out_a, want);
      end
      model_a[addr_a] = in_a;
      exp_q.push_back(in_a);
      tick();
      want = exp_q.pop_front();
      vectors++;
      if (out_a !== want) begin
        miscompares++;
        $display("[TB] FAIL rw_after_edge addr=%0d got=%h want=%h", addr_a, out_a, want);
      end
    end
    load_a = 1'b0;
  endtask

  task automatic test_clear_drops_load();
    int          cycles;
    logic [15:0] want;
    addr_a = 9'd5; in_a = 16'hBEEF; load_a = 1'b1;
    tick();
    load_a = 1'b0; clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_busy_rise got=%b want=1", busy_a);
    end
    exp_q.push_back(16'hBEEF);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_a !== want) begin
      miscompares++;
      $display("[TB] FAIL clr_not_yet_cleared got=%h want=%h", out_a, want);
    end
    tick();
    addr_a = 9'd7; in_a = 16'h1234; load_a = 1'b1;
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 600) begin
      clear_a = (cycles == 200);
      tick();
      cycles++;
    end
    load_a = 1'b0; clear_a = 1'b0;
    vectors++;
    if (cycles != 511) begin
      miscompares++;
      $display("[TB] FAIL clr_len got=%0d want=511", cycles);
    end
    vectors++;
    if (done_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clr_done got=%b want=1", done_a);
    end
    for (int i = 0; i < 2; i++) begin
      addr_a = (i == 0) ? 9'd5 : 9'd7;
      exp_q.push_back(16'h0000);
      #1;
      want = exp_q.pop_front();
      vectors++;
      if (out_a !== want) begin
        miscompares++;
        $display("[TB] FAIL clr_dropped_load addr=%0d got=%h want=%h", addr_a, out_a, want);
      end
    end
  endtask

  task automatic test_clear_and_load();
    int          cycles;
    logic [15:0] want;
    addr_a = 9'd3; in_a = 16'h5555; load_a = 1'b1;
    tick();
    in_a = 16'hAAAA; clear_a = 1'b1;
    tick();
    load_a = 1'b0; clear_a = 1'b0;
    exp_q.push_back(16'h5555);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_a !== want) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_no_write got=%h want=%h", out_a, want);
    end
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 600) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != 512) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_len got=%0d want=512", cycles);
    end
    exp_q.push_back(16'h0000);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_a !== want) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_cleared got=%h want=%h", out_a, want);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    clear_a = 1'b1;
    tick();
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 600) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != 512 || done_a !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_first len=%0d done=%b want len=512 done=1", cycles, done_a);
    end
    tick();
    vectors++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_restart busy=%b done=%b want busy=1 done=0", busy_a, done_a);
    end
    clear_a = 1'b0;
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 600) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != 512) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_len got=%0d want=512", cycles);
    end
  endtask

  task automatic test_reset_mid_clear();
    int          cycles;
    logic [15:0] want;
    addr_a = 9'd300; in_a = 16'h1357; load_a = 1'b1;
    tick();
    load_a = 1'b0; clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    repeat (100) tick();
    exp_q.push_back(16'h1357);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_a !== want) begin
      miscompares++;
      $display("[TB] FAIL mid_clear_old got=%h want=%h", out_a, want);
    end
    addr_a = 9'd50;
    exp_q.push_back(16'h0000);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_a !== want) begin
      miscompares++;
      $display("[TB] FAIL mid_clear_new got=%h want=%h", out_a, want);
    end
    rst_n_a = 1'b0;
    #1;
    vectors++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_reset_vals busy=%b done=%b want busy=1 done=0", busy_a, done_a);
    end
    tick();
    rst_n_a = 1'b1;
    cycles = 0;
    while (busy_a === 1'b1 && cycles < 600) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != 512) begin
      miscompares++;
      $display("[TB] FAIL abort_restart_len got=%0d want=512", cycles);
    end
  endtask

  task automatic test_no_clear_on_reset();
    logic [15:0] want;
    tick();
    rst_n_b = 1'b1;
    #1;
    vectors++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b_reset_idle busy=%b done=%b want busy=0 done=0", busy_b, done_b);
    end
    addr_b = 9'd10; in_b = 16'h7777; load_b = 1'b1;
    tick();
    addr_b = 9'd400; in_b = 16'hC0DE;
    tick();
    load_b = 1'b0; clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    repeat (100) tick();
    rst_n_b = 1'b0;
    #1;
    vectors++;
    if (busy_b !== 1'b0 || done_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b_abort busy=%b done=%b want busy=0 done=0", busy_b, done_b);
    end
    in_b = 16'hFFFF; load_b = 1'b1;
    tick();
    tick();
    load_b = 1'b0;
    rst_n_b = 1'b1;
    tick();
    vectors++;
    if (busy_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b_release_busy got=%b want=0", busy_b);
    end
    exp_q.push_back(16'hC0DE);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_b !== want) begin
      miscompares++;
      $display("[TB] FAIL b_word_survives got=%h want=%h", out_b, want);
    end
    addr_b = 9'd10;
    exp_q.push_back(16'h0000);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_b !== want) begin
      miscompares++;
      $display("[TB] FAIL b_partial_clear got=%h want=%h", out_b, want);
    end
  endtask

  task automatic test_small_config();
    int          cycles;
    logic [15:0] want;
    tick();
    rst_n_c = 1'b1;
    cycles = 0;
    while (busy_c === 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != 8 || done_c !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL c_clear_len len=%0d done=%b want len=8 done=1", cycles, done_c);
    end
    addr_c = 3'd7; in_c = 8'hFF; load_c = 1'b1;
    tick();
    load_c = 1'b0;
    exp_q.push_back(16'h00FF);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_c !== want[7:0]) begin
      miscompares++;
      $display("[TB] FAIL c_write_read got=%h want=%h", out_c, want[7:0]);
    end
    addr_c = 3'd0;
    exp_q.push_back(16'h0000);
    #1;
    want = exp_q.pop_front();
    vectors++;
    if (out_c !== want[7:0]) begin
      miscompares++;
      $display("[TB] FAIL c_zero_read got=%h want=%h", out_c, want[7:0]);
    end
  endtask

  initial begin
    rst_n_a = 1'b0; load_a = 1'b0; clear_a = 1'b0; in_a = '0; addr_a = '0;
    rst_n_b = 1'b0; load_b = 1'b0; clear_b = 1'b0; in_b = '0; addr_b = '0;
    rst_n_c = 1'b0; load_c = 1'b0; clear_c = 1'b0; in_c = '0; addr_c = '0;
    test_reset();
    test_random_rw();
    test_clear_drops_load();
    test_clear_and_load();
    test_back_to_back();
    test_reset_mid_clear();
    test_no_clear_on_reset();
    test_small_config();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
